// File: rtl/paralelo_serial_param_if.sv
// ----------------------------------------------------------------------------
// paralelo_serial_param_if
// Bundles the word handshake and the serial line outputs of the
// parallel-to-serial converter.
//
//   data_in     [WIDTH] parallel word offered by the sender
//   valid_in            data_in is valid
//   ready_out           converter can take a word this cycle
//   serial_out          serial bit stream
//   data_active         current bit belongs to a data word (not idle)
//   word_start          current bit is the first bit of a word
//
// master: the word source (drives data_in/valid_in, observes the rest)
// slave : the converter
// ----------------------------------------------------------------------------
interface paralelo_serial_param_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             serial_out;
    logic             data_active;
    logic             word_start;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  serial_out,
        input  data_active,
        input  word_start
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output serial_out,
        output data_active,
        output word_start
    );
endinterface

// File: rtl/paralelo_serial_param.sv
// ----------------------------------------------------------------------------
// paralelo_serial_param
// Parallel-to-serial converter for the serial link transmit path. Words of
// WIDTH bits are accepted through a valid/ready handshake into a one-word
// holding buffer and shifted out one bit per clk8f edge. When nothing is
// pending the line carries IDLE_WORD. After reset SYNC_WORDS idle words are
// always sent so the receiver can align before any data is accepted.
//
// Parameters:
//   WIDTH       word width (>= 2)
//   IDLE_WORD   idle/comma word
//   SYNC_WORDS  idle words sent after reset (>= 1)
//   LSB_FIRST   0: bit WIDTH-1 leaves first, 1: bit 0 leaves first
//
// Ports:
//   clk8f   bit-rate clock
//   reset   synchronous, active-high reset
//   link    slave side of paralelo_serial_param_if
// ----------------------------------------------------------------------------
module paralelo_serial_param #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD  = 8'hBC,
    parameter int               SYNC_WORDS = 4,
    parameter bit               LSB_FIRST  = 1'b0
) (
    input logic                    clk8f,
    input logic                    reset,
    paralelo_serial_param_if.slave link
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam int               SYNC_W   = $clog2(SYNC_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    // Leaving SYNC one word early lets the first data word be handed over
    // during the last sync word and follow it without a gap.
    localparam logic [SYNC_W-1:0] SYNC_LAST =
        SYNC_W'((SYNC_WORDS >= 2) ? (SYNC_WORDS - 2) : 0);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // With a single sync word the block is ready straight out of reset.
    localparam state_t RST_STATE = (SYNC_WORDS == 1) ? ST_RUN : ST_SYNC;

    state_t            state, state_nxt;
    logic [SYNC_W-1:0] sync_cnt, sync_cnt_nxt;
    logic [WIDTH-1:0]  sh;
    logic [WIDTH-1:0]  hold;
    logic              hold_full;
    logic              data_flag;
    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic              ready;
    logic              xfer;

    // Move the shift register one place toward the output end.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        if (LSB_FIRST)
            return {1'b0, w[WIDTH-1:1]};
        else
            return {w[WIDTH-2:0], 1'b0};
    endfunction

    assign boundary = (cnt == CNT_LAST);
    // The reset term keeps ready low while reset is held even when the
    // reset state is already RUN (SYNC_WORDS == 1).
    assign ready    = (state == ST_RUN) && !hold_full && !reset;
    assign xfer     = link.valid_in && ready;

    // ---- FSM: state register ----
    always_ff @(posedge clk8f) begin
        if (reset) begin
            state    <= RST_STATE;
            sync_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
        end
    end

    // ---- FSM: next state, counts idle words completed during SYNC ----
    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        if (state == ST_SYNC && boundary) begin
            if (sync_cnt == SYNC_LAST)
                state_nxt = ST_RUN;
            else
                sync_cnt_nxt = sync_cnt + SYNC_W'(1);
        end
    end

    // ---- Datapath: holding buffer, shifter and bit counter ----
    always_ff @(posedge clk8f) begin
        if (reset) begin
            sh        <= IDLE_WORD;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            data_flag <= 1'b0;
        end else if (boundary) begin
            cnt <= '0;
            // hold cannot be full and accept a word on the same edge, since
            // ready is low while it is full; bypass covers the empty case.
            if (hold_full) begin
                sh        <= hold;
                hold_full <= 1'b0;
                data_flag <= 1'b1;
            end else if (xfer) begin
                sh        <= link.data_in;
                data_flag <= 1'b1;
            end else begin
                sh        <= IDLE_WORD;
                data_flag <= 1'b0;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
            sh  <= shift_out(sh);
            if (xfer) begin
                hold      <= link.data_in;
                hold_full <= 1'b1;
            end
        end
    end

    // Output bit comes straight from the shifter, no extra register.
    assign link.serial_out  = LSB_FIRST ? sh[0] : sh[WIDTH-1];
    assign link.word_start  = (cnt == '0);
    assign link.data_active = data_flag;
    assign link.ready_out   = ready;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// ----------------------------------------------------------------------------
// tb_paralelo_serial_param
// Two converters: the default configuration (8 bit, MSB first, 4 sync words)
// and a 10 bit, LSB first, single-sync-word one. Words accepted by the
// handshake are queued as expected line words; at every word start the next
// queued word (or the idle word if none) becomes the expected word and its
// bits are checked cycle by cycle together with data_active, word_start and
// ready_out.
// ----------------------------------------------------------------------------
module tb_paralelo_serial_param;

    logic clk8f = 1'b0;
    logic rst8  = 1'b1;
    logic rst10 = 1'b1;

    always #5 clk8f = ~clk8f;

    paralelo_serial_param_if #(.WIDTH(8))  m8 ();
    paralelo_serial_param_if #(.WIDTH(10)) m10 ();

    paralelo_serial_param dut8 (
        .clk8f (clk8f),
        .reset (rst8),
        .link  (m8)
    );

    paralelo_serial_param #(
        .WIDTH      (10),
        .IDLE_WORD  (10'h17C),
        .SYNC_WORDS (1),
        .LSB_FIRST  (1'b1)
    ) dut10 (
        .clk8f (clk8f),
        .reset (rst10),
        .link  (m10)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] sbq [$];
    bit         sel10  = 1'b0;
    int         cyc    = 0;
    int         bitpos = 0;
    bit         pend   = 1'b0;
    logic [9:0] cur    = '0;
    bit         cur_da = 1'b0;
    logic [9:0] sw [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d cycle %0d): got %0h, expected %0h",
                     tag, sel10 ? 10 : 8, cyc, obs, exp);
        end
    endtask

    function automatic int cfg_w();
        return sel10 ? 10 : 8;
    endfunction

    function automatic logic [9:0] cfg_idle();
        return sel10 ? 10'h17C : 10'h0BC;
    endfunction

    // first cycle in which ready_out may be 1: (SYNC_WORDS-1)*WIDTH
    function automatic int cfg_sync_cyc();
        return sel10 ? 0 : 24;
    endfunction

    function automatic logic first_bit(input logic [9:0] w);
        return sel10 ? w[0] : w[cfg_w()-1];
    endfunction

    task automatic drive(input logic v, input logic [9:0] d);
        if (sel10) begin
            m10.valid_in = v;
            m10.data_in  = d;
        end else begin
            m8.valid_in = v;
            m8.data_in  = d[7:0];
        end
    endtask

    // Check one cycle of output, record a transfer, advance to the next cycle.
    task automatic cycle(output bit xfer);
        logic       so, da, ws, rdy, v, eb;
        logic [9:0] d;
        int         w;
        #1;
        w = cfg_w();
        if (sel10) begin
            so = m10.serial_out; da = m10.data_active; ws = m10.word_start;
            rdy = m10.ready_out; v = m10.valid_in;     d = m10.data_in;
        end else begin
            so = m8.serial_out;  da = m8.data_active;  ws = m8.word_start;
            rdy = m8.ready_out;  v = m8.valid_in;      d = {2'b00, m8.data_in};
        end
        if (bitpos == 0) begin
            if (sbq.size() > 0) begin
                cur    = sbq.pop_front();
                cur_da = 1'b1;
            end else begin
                cur    = cfg_idle();
                cur_da = 1'b0;
            end
        end
        eb = sel10 ? cur[bitpos] : cur[w-1-bitpos];
        chk("serial_out",  32'(so),  32'(eb));
        chk("data_active", 32'(da),  32'(cur_da));
        chk("word_start",  32'(ws),  32'(bitpos == 0));
        chk("ready_out",   32'(rdy), 32'((cyc >= cfg_sync_cyc()) && !pend));
        xfer = v && rdy;
        if (xfer) sbq.push_back(d);
        if (bitpos == w - 1) pend = 1'b0;
        else if (xfer)       pend = 1'b1;
        bitpos = (bitpos == w - 1) ? 0 : bitpos + 1;
        cyc++;
        @(negedge clk8f);
    endtask

    // Hold reset for n edges, check the in-reset outputs, then release.
    task automatic do_reset(input int n);
        logic so, da, ws, rdy;
        drive(1'b0, '0);
        if (sel10) rst10 = 1'b1; else rst8 = 1'b1;
        repeat (n) @(negedge clk8f);
        #1;
        if (sel10) begin
            so = m10.serial_out; da = m10.data_active; ws = m10.word_start; rdy = m10.ready_out;
        end else begin
            so = m8.serial_out;  da = m8.data_active;  ws = m8.word_start;  rdy = m8.ready_out;
        end
        chk("rst_serial_out",  32'(so),  32'(first_bit(cfg_idle())));
        chk("rst_data_active", 32'(da),  32'd0);
        chk("rst_word_start",  32'(ws),  32'd1);
        chk("rst_ready_out",   32'(rdy), 32'd0);
        if (sel10) rst10 = 1'b0; else rst8 = 1'b0;
        sbq.delete();
        cyc    = 0;
        bitpos = 0;
        pend   = 1'b0;
    endtask

    // Run up to (not including) cycle 'last', offering vd in cycle vcyc only.
    task automatic run_to(input int last, input int vcyc, input logic [9:0] vd);
        bit x;
        while (cyc < last) begin
            if (cyc == vcyc) drive(1'b1, vd);
            else             drive(1'b0, '0);
            cycle(x);
        end
    endtask

    initial begin
        bit x;
        int k;
        m8.valid_in  = 1'b0;
        m8.data_in   = '0;
        m10.valid_in = 1'b0;
        m10.data_in  = '0;
        sw[0] = 10'h001;
        sw[1] = 10'h0FF;
        sw[2] = 10'h000;
        @(negedge clk8f);

        // idle stream and sync sequence
        sel10 = 1'b0;
        do_reset(2);
        run_to(40, -1, '0);

        // hold path: transfer in cycle 25
        do_reset(1);
        run_to(48, 25, 10'h0A5);
        chk("hold_drained", 32'(sbq.size()), 32'd0);

        // bypass: transfer on the boundary cycle 31
        do_reset(1);
        run_to(48, 31, 10'h03C);
        chk("bypass_drained", 32'(sbq.size()), 32'd0);

        // streaming: valid held from cycle 24, sender advances on each transfer
        do_reset(1);
        k = 0;
        while (cyc < 64) begin
            if (cyc >= 24 && k < 3) drive(1'b1, sw[k]);
            else                    drive(1'b0, '0);
            cycle(x);
            if (x) k++;
        end
        chk("stream_words", 32'(k), 32'd3);

        // reset mid-word with a second word waiting in hold
        do_reset(1);
        run_to(25, 24, 10'h05A);
        run_to(35, 33, 10'h0C3);
        chk("hold_pending", 32'(pend), 32'd1);
        do_reset(2);
        run_to(48, -1, '0);

        // 10 bit, LSB first, ready straight after reset
        rst8  = 1'b1;
        sel10 = 1'b1;
        do_reset(1);
        run_to(30, 0, 10'h001);
        chk("w10_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
